// File: rtl/uart_tx_pkg.sv
// -----------------------------------------------------------------------------
// uart_tx_pkg
// Shared UART definitions: the transmitter FSM state encoding, the idle line
// level and the parity helper. Kept separate so a future receiver can reuse
// the same encoding and level.
// -----------------------------------------------------------------------------
package uart_tx_pkg;

    // 3-bit state encoding for the serialiser FSM
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARM    = 3'd1,
        ST_START  = 3'd2,
        ST_DATA   = 3'd3,
        ST_PARITY = 3'd4,
        ST_STOP   = 3'd5
    } uart_state_e;

    // Line level while no frame is in flight (also the stop-bit level)
    localparam logic UART_IDLE_LEVEL = 1'b1;

    // Widest data field supported by the parity helper
    localparam int unsigned UART_MAX_DATA_BITS = 9;

    // Parity over up to 9 data bits; callers zero-extend narrower words,
    // which does not change the XOR reduction. odd=1 inverts the result.
    function automatic logic calc_parity(input logic [8:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// -----------------------------------------------------------------------------
// uart_tx_if
// Byte handshake between the host-side byte source and the UART transmitter.
//   s_data  : word to send, sampled when s_valid & s_ready
//   s_valid : s_data is valid
//   s_ready : transmitter can accept a word this cycle
// master = byte source, slave = transmitter.
// -----------------------------------------------------------------------------
interface uart_tx_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] s_data;
    logic                 s_valid;
    logic                 s_ready;

    modport master (
        output s_data,
        output s_valid,
        input  s_ready
    );

    modport slave (
        input  s_data,
        input  s_valid,
        output s_ready
    );
endinterface

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
// UART serialiser. Accepts a word over a valid/ready handshake and shifts it
// onto the TX line LSB first, one bit per baud_tick interval:
//   start(0), DATA_BITS data, optional parity, STOP_BITS stop(1).
// Ports:
//   clk       : system clock (same domain as the baud tick generator)
//   rst       : synchronous, active-high reset
//   baud_tick : 1-clk strobe, one per bit period
//   bus       : slave side of the byte handshake (s_data/s_valid/s_ready)
//   tx        : serial line, idle high, registered
//   busy      : high from accept until the end of the frame, registered
//   done      : 1-clk pulse at the end of each completed frame, registered
// -----------------------------------------------------------------------------
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter bit PARITY_EN  = 1'b0,
    parameter bit PARITY_ODD = 1'b0,
    parameter int STOP_BITS  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        baud_tick,
    uart_tx_if.slave    bus,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    localparam int                   BIT_CNT_W = $clog2(DATA_BITS);
    localparam logic [BIT_CNT_W-1:0] BIT_LAST  = BIT_CNT_W'(DATA_BITS - 1);
    // Value of stop_cnt_r on the tick that ends the final stop bit
    localparam logic                 STOP_LAST = (STOP_BITS == 2) ? 1'b1 : 1'b0;

    uart_state_e          state_r;
    logic [DATA_BITS-1:0] shift_r;
    logic                 par_r;
    logic [BIT_CNT_W-1:0] bit_cnt_r;
    logic                 stop_cnt_r;
    logic                 tx_r;
    logic                 busy_r;
    logic                 done_r;
    logic                 ready_s;
    logic                 accept_s;

    // Ready is combinational from state so a word is taken the cycle after done
    assign ready_s     = (state_r == ST_IDLE) & ~rst;
    assign accept_s    = bus.s_valid & ready_s;
    assign bus.s_ready = ready_s;

    assign tx   = tx_r;
    assign busy = busy_r;
    assign done = done_r;

    // Frame FSM with shift register, counters and registered line outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            shift_r    <= '0;
            par_r      <= 1'b0;
            bit_cnt_r  <= '0;
            stop_cnt_r <= 1'b0;
            tx_r       <= UART_IDLE_LEVEL;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    tx_r <= UART_IDLE_LEVEL;
                    // A tick coinciding with accept is not used: ARM waits for
                    // the next one so the start bit is always a full period.
                    if (accept_s) begin
                        shift_r <= bus.s_data;
                        par_r   <= calc_parity(9'(bus.s_data), PARITY_ODD);
                        busy_r  <= 1'b1;
                        state_r <= ST_ARM;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ARM: begin
                    if (baud_tick) begin
                        tx_r    <= 1'b0;
                        state_r <= ST_START;
                    end else begin
                        tx_r    <= UART_IDLE_LEVEL;
                    end
                end
                ST_START: begin
                    if (baud_tick) begin
                        tx_r      <= shift_r[0];
                        bit_cnt_r <= '0;
                        state_r   <= ST_DATA;
                    end else begin
                        tx_r      <= 1'b0;
                    end
                end
                ST_DATA: begin
                    if (baud_tick) begin
                        // shift_r[0] is the bit on the line; [1] is the next one
                        shift_r <= {1'b0, shift_r[DATA_BITS-1:1]};
                        if (bit_cnt_r == BIT_LAST) begin
                            stop_cnt_r <= 1'b0;
                            if (PARITY_EN) begin
                                tx_r    <= par_r;
                                state_r <= ST_PARITY;
                            end else begin
                                tx_r    <= UART_IDLE_LEVEL;
                                state_r <= ST_STOP;
                            end
                        end else begin
                            bit_cnt_r <= bit_cnt_r + BIT_CNT_W'(1);
                            tx_r      <= shift_r[1];
                        end
                    end else begin
                        tx_r <= tx_r;
                    end
                end
                ST_PARITY: begin
                    if (baud_tick) begin
                        tx_r       <= UART_IDLE_LEVEL;
                        stop_cnt_r <= 1'b0;
                        state_r    <= ST_STOP;
                    end else begin
                        tx_r       <= par_r;
                    end
                end
                ST_STOP: begin
                    tx_r <= UART_IDLE_LEVEL;
                    if (baud_tick) begin
                        if (stop_cnt_r == STOP_LAST) begin
                            stop_cnt_r <= 1'b0;
                            busy_r     <= 1'b0;
                            done_r     <= 1'b1;
                            state_r    <= ST_IDLE;
                        end else begin
                            stop_cnt_r <= 1'b1;
                        end
                    end else begin
                        stop_cnt_r <= stop_cnt_r;
                    end
                end
                default: begin
                    tx_r    <= UART_IDLE_LEVEL;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx
// Four transmitter instances share clock, reset and baud_tick:
//   0 = 8N1 default, 1 = even parity, 2 = odd parity, 3 = two stop bits.
// baud_tick pulses every 4 clks. Outputs are sampled 1 time unit after posedge.
// -----------------------------------------------------------------------------
module tb_uart_tx;

    logic       clk;
    logic       rst;
    logic       baud_tick;
    logic       s_valid_v [4];
    logic [7:0] s_data_v  [4];
    logic       s_ready_w [4];
    logic       tx_w      [4];
    logic       busy_w    [4];
    logic       done_w    [4];

    int n_checks = 0;
    int n_fail   = 0;
    int phase    = 0;

    uart_tx_if #(.DATA_BITS(8)) bus_a ();
    uart_tx_if #(.DATA_BITS(8)) bus_p ();
    uart_tx_if #(.DATA_BITS(8)) bus_o ();
    uart_tx_if #(.DATA_BITS(8)) bus_s ();

    assign bus_a.s_valid = s_valid_v[0];
    assign bus_a.s_data  = s_data_v[0];
    assign s_ready_w[0]  = bus_a.s_ready;
    assign bus_p.s_valid = s_valid_v[1];
    assign bus_p.s_data  = s_data_v[1];
    assign s_ready_w[1]  = bus_p.s_ready;
    assign bus_o.s_valid = s_valid_v[2];
    assign bus_o.s_data  = s_data_v[2];
    assign s_ready_w[2]  = bus_o.s_ready;
    assign bus_s.s_valid = s_valid_v[3];
    assign bus_s.s_data  = s_data_v[3];
    assign s_ready_w[3]  = bus_s.s_ready;

    uart_tx #(.DATA_BITS(8), .PARITY_EN(1'b0), .PARITY_ODD(1'b0), .STOP_BITS(1)) dut_a (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .bus(bus_a.slave),
        .tx(tx_w[0]), .busy(busy_w[0]), .done(done_w[0]));
    uart_tx #(.DATA_BITS(8), .PARITY_EN(1'b1), .PARITY_ODD(1'b0), .STOP_BITS(1)) dut_p (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .bus(bus_p.slave),
        .tx(tx_w[1]), .busy(busy_w[1]), .done(done_w[1]));
    uart_tx #(.DATA_BITS(8), .PARITY_EN(1'b1), .PARITY_ODD(1'b1), .STOP_BITS(1)) dut_o (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .bus(bus_o.slave),
        .tx(tx_w[2]), .busy(busy_w[2]), .done(done_w[2]));
    uart_tx #(.DATA_BITS(8), .PARITY_EN(1'b0), .PARITY_ODD(1'b0), .STOP_BITS(2)) dut_s (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .bus(bus_s.slave),
        .tx(tx_w[3]), .busy(busy_w[3]), .done(done_w[3]));

    // Free-running system clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One frame vector: exp[11] is the line level of bit period 0
    typedef struct {
        int          idx;
        logic [7:0]  data;
        int          nper;
        logic [11:0] exp;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // One clock: baud_tick high on every 4th edge, then sample after the edge
    task automatic step();
        baud_tick = (phase == 3);
        phase = (phase + 1) % 4;
        @(posedge clk);
        #1;
    endtask

    // Step until the start bit appears; cyc returns the number of steps taken
    task automatic wait_start(input int idx, input string name, output int cyc);
        cyc = 0;
        while (tx_w[idx] !== 1'b0 && cyc < 12) begin
            step();
            cyc++;
        end
        chk({name, "_start_seen"}, 32'(tx_w[idx]), 32'd0);
    endtask

    // Entered on the first start-bit sample; checks every cycle of each period
    // and ends on the sample that should carry the done pulse.
    task automatic check_frame(input int idx, input int nper, input logic [11:0] exp,
                               input bit scramble, input string name);
        logic ok;
        for (int p = 0; p < nper; p++) begin
            ok = 1'b1;
            for (int c = 0; c < 4; c++) begin
                if (!(p == 0 && c == 0)) begin
                    if (scramble) s_data_v[idx] = 8'($urandom);
                    step();
                end
                if (tx_w[idx] !== exp[11-p] || done_w[idx] !== 1'b0 ||
                    s_ready_w[idx] !== 1'b0 || busy_w[idx] !== 1'b1)
                    ok = 1'b0;
            end
            chk($sformatf("%s_period%0d", name, p), 32'(ok), 32'd1);
        end
        step();
        chk({name, "_done_busy_tx"}, {29'd0, done_w[idx], busy_w[idx], tx_w[idx]}, 32'b100 | 32'b001);
    endtask

    initial begin
        int   cyc;
        logic ok;

        // expected frames, hand-derived LSB first
        vecs[0] = '{idx: 0, data: 8'hA5, nper: 10, exp: 12'b0101001011_00};
        vecs[1] = '{idx: 0, data: 8'h3C, nper: 10, exp: 12'b0001111001_00};
        vecs[2] = '{idx: 1, data: 8'h07, nper: 11, exp: 12'b01110000011_0};
        vecs[3] = '{idx: 2, data: 8'h07, nper: 11, exp: 12'b01110000001_0};
        vecs[4] = '{idx: 3, data: 8'h00, nper: 11, exp: 12'b00000000011_0};
        vecs[5] = '{idx: 1, data: 8'hFF, nper: 11, exp: 12'b01111111101_0};

        rst       = 1'b1;
        baud_tick = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s_valid_v[i] = 1'b0;
            s_data_v[i]  = 8'h00;
        end

        // reset state, with s_valid asserted to show nothing is accepted
        s_valid_v[0] = 1'b1;
        step(); step(); step();
        for (int i = 0; i < 4; i++)
            chk($sformatf("reset_dut%0d_tx_busy_done_ready", i),
                {28'd0, tx_w[i], busy_w[i], done_w[i], s_ready_w[i]}, 32'b1000);
        s_valid_v[0] = 1'b0;
        rst = 1'b0;
        step();
        for (int i = 0; i < 4; i++)
            chk($sformatf("post_reset_dut%0d_ready", i), 32'(s_ready_w[i]), 32'd1);

        // table-driven single frames
        for (int v = 0; v < 6; v++) begin
            s_data_v[vecs[v].idx]  = vecs[v].data;
            s_valid_v[vecs[v].idx] = 1'b1;
            step();
            chk($sformatf("vec%0d_accept_busy", v), 32'(busy_w[vecs[v].idx]), 32'd1);
            s_valid_v[vecs[v].idx] = 1'b0;
            s_data_v[vecs[v].idx]  = ~vecs[v].data;
            wait_start(vecs[v].idx, $sformatf("vec%0d", v), cyc);
            check_frame(vecs[v].idx, vecs[v].nper, vecs[v].exp, 1'b1, $sformatf("vec%0d", v));
            step();
            chk($sformatf("vec%0d_done_one_cycle", v), 32'(done_w[vecs[v].idx]), 32'd0);
        end

        // back-to-back with s_valid held: 0x55 then 0xAA
        s_data_v[0]  = 8'h55;
        s_valid_v[0] = 1'b1;
        step();
        chk("b2b_accept1", 32'(busy_w[0]), 32'd1);
        s_data_v[0] = 8'hAA;
        wait_start(0, "b2b1", cyc);
        check_frame(0, 10, 12'b0101010101_00, 1'b1, "b2b1");
        s_data_v[0] = 8'hAA;
        chk("b2b_ready_after_done", 32'(s_ready_w[0]), 32'd1);
        step();
        chk("b2b_accept2_busy_tx", {30'd0, busy_w[0], tx_w[0]}, 32'b11);
        s_valid_v[0] = 1'b0;
        wait_start(0, "b2b2", cyc);
        chk("b2b_gap_steps_after_accept", 32'(cyc), 32'd3);
        check_frame(0, 10, 12'b0010101011_00, 1'b0, "b2b2");
        step();

        // accept in the same cycle as a baud_tick: start bit waits a full period
        phase        = 3;
        s_data_v[0]  = 8'hC3;
        s_valid_v[0] = 1'b1;
        step();
        chk("tick_accept_busy_tx", {30'd0, busy_w[0], tx_w[0]}, 32'b11);
        s_valid_v[0] = 1'b0;
        wait_start(0, "tick_accept", cyc);
        chk("tick_accept_start_delay", 32'(cyc), 32'd4);
        check_frame(0, 10, 12'b0110000111_00, 1'b0, "tick_accept");
        step();

        // reset for one clock during data bit 3 (bit period 4)
        s_data_v[0]  = 8'hA5;
        s_valid_v[0] = 1'b1;
        step();
        s_valid_v[0] = 1'b0;
        wait_start(0, "abort", cyc);
        for (int i = 0; i < 17; i++) step();
        chk("abort_in_data_bit3_busy", 32'(busy_w[0]), 32'd1);
        rst = 1'b1;
        step();
        chk("abort_rst_tx_busy_done_ready", {28'd0, tx_w[0], busy_w[0], done_w[0], s_ready_w[0]}, 32'b1000);
        rst = 1'b0;
        step();
        chk("abort_release_tx_busy_ready", {29'd0, tx_w[0], busy_w[0], s_ready_w[0]}, 32'b101);
        ok = 1'b1;
        for (int i = 0; i < 60; i++) begin
            step();
            if (done_w[0] !== 1'b0 || tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0) ok = 1'b0;
        end
        chk("abort_no_done_line_idle", 32'(ok), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
